// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage RISC-V core.
// Registers decoded operands and control for EX. Detects load-use hazards:
// it stalls PC and IF/ID and inserts a bubble. Branch/jump flushes from EX
// also insert a bubble. Load-use bubbles are counted in bubble_count.
// Optional feature macro: ID_EX_WB_BYPASS_EN. When it is defined, the WB
// write data is forwarded into the operands captured from ID.
module id_ex_stage #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             id_memwrite,
   input  logic             id_memtoreg,
   input  logic             id_branch,
   input  logic             id_jump,
   input  logic             id_alusrc,
   input  logic [1:0]       id_aluop,
   input  logic             ex_flush,
   input  logic             wb_regwrite,
   input  logic [4:0]       wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_memtoreg,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic             ex_alusrc,
   output logic [1:0]       ex_aluop,
   output logic             stall,
   output logic [CNT_W-1:0] bubble_count
);

   // All EX-side state is kept in one record, so a bubble is simply all-zero.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic            memtoreg;
      logic            branch;
      logic            jump;
      logic            alusrc;
      logic [1:0]      aluop;
   } ex_t;

   ex_t             ex_d, ex_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic            lu;
   logic            stall_int;
   logic [XLEN-1:0] rs1_val, rs2_val;

   // Load-use detection. Both rs fields are always compared: a false match
   // costs only one cycle. Flush wins, because the ID instruction is wrong-path.
   always_comb begin
      lu = id_valid && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
           ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
      stall_int = lu && !ex_flush;
   end

   // Operand source selection: register file data, or WB data when bypass is built in.
   always_comb begin
      rs1_val = id_rs1_data;
      rs2_val = id_rs2_data;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1)) rs1_val = wb_data;
      if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2)) rs2_val = wb_data;
`endif
   end

`ifndef ID_EX_WB_BYPASS_EN
   logic wb_unused;
   assign wb_unused = ^{wb_regwrite, wb_rd, wb_data};
`endif

   // Next EX contents. A flush or a load-use hazard loads a bubble; otherwise
   // the ID fields load as-is. An invalid ID slot still loads its fields, with valid=0.
   always_comb begin
      ex_d = '0;
      if (!(ex_flush || lu)) begin
         ex_d.valid    = id_valid;
         ex_d.pc       = id_pc;
         ex_d.rs1      = id_rs1;
         ex_d.rs2      = id_rs2;
         ex_d.rd       = id_rd;
         ex_d.rs1_data = rs1_val;
         ex_d.rs2_data = rs2_val;
         ex_d.imm      = id_imm;
         ex_d.regwrite = id_regwrite;
         ex_d.memread  = id_memread;
         ex_d.memwrite = id_memwrite;
         ex_d.memtoreg = id_memtoreg;
         ex_d.branch   = id_branch;
         ex_d.jump     = id_jump;
         ex_d.alusrc   = id_alusrc;
         ex_d.aluop    = id_aluop;
      end
   end

   // Bubble counter: counts load-use stalls only and wraps naturally.
   always_comb begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, stall_int};
   end

   // Pipeline register and counter, with asynchronous clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_pc        = ex_q.pc;
   assign ex_rs1       = ex_q.rs1;
   assign ex_rs2       = ex_q.rs2;
   assign ex_rd        = ex_q.rd;
   assign ex_rs1_data  = ex_q.rs1_data;
   assign ex_rs2_data  = ex_q.rs2_data;
   assign ex_imm       = ex_q.imm;
   assign ex_regwrite  = ex_q.regwrite;
   assign ex_memread   = ex_q.memread;
   assign ex_memwrite  = ex_q.memwrite;
   assign ex_memtoreg  = ex_q.memtoreg;
   assign ex_branch    = ex_q.branch;
   assign ex_jump      = ex_q.jump;
   assign ex_alusrc    = ex_q.alusrc;
   assign ex_aluop     = ex_q.aluop;
   assign stall        = stall_int;
   assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage, built with CNT_W=4 so that counter wrap is reachable.
// The reference model tracks the instruction record held in EX and the bubble count.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] rs1_data;
      logic [63:0] rs2_data;
      logic [63:0] imm;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
      logic        branch;
      logic        jump;
      logic        alusrc;
      logic [1:0]  aluop;
   } rec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   rec_t        id = '0;
   logic        flush = 1'b0;
   logic        wb_regwrite = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [63:0] wb_data = '0;

   logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
   logic        ex_branch, ex_jump, ex_alusrc, stall;
   logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [1:0]  ex_aluop;
   logic [3:0]  bubble_count;
   rec_t        obs;

   rec_t        exp_rec = '0;
   logic [3:0]  exp_cnt = '0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(64), .CNT_W(4)) dut (
      .clk(clk), .rstn(rstn),
      .id_valid(id.valid), .id_pc(id.pc), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
      .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data), .id_imm(id.imm),
      .id_regwrite(id.regwrite), .id_memread(id.memread), .id_memwrite(id.memwrite),
      .id_memtoreg(id.memtoreg), .id_branch(id.branch), .id_jump(id.jump),
      .id_alusrc(id.alusrc), .id_aluop(id.aluop),
      .ex_flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
      .stall(stall), .bubble_count(bubble_count)
   );

   assign obs = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
                 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_jump,
                 ex_alusrc, ex_aluop};

   // A load-use hazard exists when a valid ID instruction reads the
   // destination of a valid non-x0 load currently held in EX.
   function automatic logic model_lu();
      return id.valid && exp_rec.valid && exp_rec.memread && (exp_rec.rd != 5'd0) &&
             ((exp_rec.rd == id.rs1) || (exp_rec.rd == id.rs2));
   endfunction

   function automatic rec_t rnd_rec();
      rec_t r;
      r.valid    = ($urandom_range(0, 7) != 0);
      r.pc       = {$urandom, $urandom};
      r.rs1      = 5'($urandom_range(0, 7));
      r.rs2      = 5'($urandom_range(0, 7));
      r.rd       = 5'($urandom_range(0, 7));
      r.rs1_data = {$urandom, $urandom};
      r.rs2_data = {$urandom, $urandom};
      r.imm      = {$urandom, $urandom};
      r.regwrite = 1'($urandom);
      r.memread  = ($urandom_range(0, 2) == 0);
      r.memwrite = 1'($urandom);
      r.memtoreg = 1'($urandom);
      r.branch   = 1'($urandom);
      r.jump     = 1'($urandom);
      r.alusrc   = 1'($urandom);
      r.aluop    = 2'($urandom);
      return r;
   endfunction

   // One clock edge. The model advances using the inputs present at that edge.
   task automatic advance();
      logic lu;
      @(posedge clk);
      lu = model_lu();
      if (flush || lu) begin
         exp_rec = '0;
      end else begin
         exp_rec = id;
`ifdef ID_EX_WB_BYPASS_EN
         if (wb_regwrite && wb_rd != 0 && wb_rd == id.rs1) exp_rec.rs1_data = wb_data;
         if (wb_regwrite && wb_rd != 0 && wb_rd == id.rs2) exp_rec.rs2_data = wb_data;
`endif
      end
      if (lu && !flush) exp_cnt = exp_cnt + 4'd1;
      #1;
   endtask

   // Set up a load whose source fields cannot cause a hazard of their own.
   task automatic issue_load(input logic [4:0] rd);
      id = rnd_rec();
      id.valid = 1'b1; id.memread = 1'b1; id.rd = rd; id.rs1 = 5'd0; id.rs2 = 5'd0;
      advance();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      id = rnd_rec();
      repeat (3) @(posedge clk);
      #1;
      total++; if (obs !== '0) begin bad++; $display("FAIL reset_fields got=%h want=0", obs); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      total++; if (bubble_count !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bubble_count); end
      rstn = 1'b1;
      exp_rec = '0; exp_cnt = '0;
   endtask

   task automatic test_load_use();
      issue_load(5'd5);
      total++; if (obs !== exp_rec) begin bad++; $display("FAIL lu_load got=%h want=%h", obs, exp_rec); end
      id = rnd_rec();
      id.valid = 1'b1; id.rs1 = 5'd3; id.rs2 = 5'd5;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall); end
      advance();
      total++; if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
         bad++; $display("FAIL lu_bubble got valid=%b rd=%0d want valid=0 rd=0", ex_valid, ex_rd); end
      total++; if (obs !== '0) begin bad++; $display("FAIL lu_bubble_all got=%h want=0", obs); end
      total++; if (bubble_count !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", bubble_count); end
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release got=%b want=0", stall); end
      advance();
      total++; if (obs !== id) begin bad++; $display("FAIL lu_advance got=%h want=%h", obs, id); end
   endtask

   task automatic test_x0();
      logic [3:0] c0;
      issue_load(5'd0);
      id = rnd_rec();
      id.valid = 1'b1; id.rs1 = 5'd0; id.memread = 1'b0;
      c0 = bubble_count;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b want=0", stall); end
      advance();
      total++; if (obs !== id) begin bad++; $display("FAIL x0_advance got=%h want=%h", obs, id); end
      total++; if (bubble_count !== c0) begin bad++; $display("FAIL x0_cnt got=%0d want=%0d", bubble_count, c0); end
   endtask

   task automatic test_flush();
      logic [3:0] c0;
      issue_load(5'd5);
      id = rnd_rec();
      id.valid = 1'b1; id.rs2 = 5'd5;
      flush = 1'b1;
      c0 = bubble_count;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall); end
      advance();
      flush = 1'b0;
      total++; if (obs !== '0) begin bad++; $display("FAIL flush_bubble got=%h want=0", obs); end
      total++; if (bubble_count !== c0) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", bubble_count, c0); end
   endtask

   task automatic test_bypass();
      logic [63:0] want;
      id = rnd_rec();
      id.valid = 1'b1; id.memread = 1'b0; id.rs1 = 5'd7; id.rs2 = 5'd2; id.rs1_data = 64'h1;
      wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD;
`ifdef ID_EX_WB_BYPASS_EN
      want = 64'hDEAD;
`else
      want = 64'h1;
`endif
      advance();
      total++; if (ex_rs1_data !== want) begin bad++; $display("FAIL bypass_rs1 got=%h want=%h", ex_rs1_data, want); end
      total++; if (ex_rs2_data !== id.rs2_data) begin bad++; $display("FAIL bypass_rs2 got=%h want=%h", ex_rs2_data, id.rs2_data); end
      // Writes to x0 are never forwarded.
      id = rnd_rec();
      id.valid = 1'b1; id.memread = 1'b0; id.rs1 = 5'd0; id.rs2 = 5'd0;
      wb_rd = 5'd0;
      advance();
      total++; if (ex_rs1_data !== id.rs1_data) begin bad++; $display("FAIL bypass_x0 got=%h want=%h", ex_rs1_data, id.rs1_data); end
      wb_regwrite = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         id = rnd_rec();
         flush = ($urandom_range(0, 7) == 0);
         wb_regwrite = 1'($urandom);
         wb_rd = 5'($urandom_range(0, 7));
         wb_data = {$urandom, $urandom};
         #1;
         total++; if (stall !== (model_lu() && !flush)) begin
            bad++; $display("FAIL rand_stall i=%0d got=%b want=%b", i, stall, model_lu() && !flush); end
         advance();
         total++; if (obs !== exp_rec) begin bad++; $display("FAIL rand_fields i=%0d got=%h want=%h", i, obs, exp_rec); end
         total++; if (bubble_count !== exp_cnt) begin
            bad++; $display("FAIL rand_cnt i=%0d got=%0d want=%0d", i, bubble_count, exp_cnt); end
      end
      flush = 1'b0; wb_regwrite = 1'b0;
   endtask

   task automatic test_reset_mid_stall();
      issue_load(5'd9);
      id = rnd_rec();
      id.valid = 1'b1; id.rs1 = 5'd9;
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst_pre_stall got=%b want=1", stall); end
      #1 rstn = 1'b0;
      #1;
      total++; if (obs !== '0) begin bad++; $display("FAIL rst_mid_fields got=%h want=0", obs); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", stall); end
      total++; if (bubble_count !== 4'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d want=0", bubble_count); end
      @(negedge clk);
      rstn = 1'b1;
      exp_rec = '0; exp_cnt = '0;
      advance();
      total++; if (obs !== id) begin bad++; $display("FAIL rst_first_load got=%h want=%h", obs, id); end
   endtask

   task automatic test_wrap();
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_rec = '0; exp_cnt = '0;
      for (int i = 0; i < 16; i++) begin
         issue_load(5'(i + 1));
         id = rnd_rec();
         id.valid = 1'b1; id.memread = 1'b0; id.rs1 = 5'(i + 1);
         advance();
         total++; if (bubble_count !== 4'(i + 1)) begin
            bad++; $display("FAIL wrap_step i=%0d got=%0d want=%0d", i, bubble_count, 4'(i + 1)); end
         advance();
      end
      total++; if (bubble_count !== 4'd0) begin bad++; $display("FAIL wrap_final got=%0d want=0", bubble_count); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_x0();
      test_flush();
      test_bypass();
      test_random();
      test_reset_mid_stall();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
